// File: rtl/stream_capture_pkg.sv
// rtl/stream_capture_pkg.sv - shared types and constants for stream_capture
// Purpose: FSM state encoding, register word offsets, CONST value and RAM sizing helper.
// Ports: none (package).
package stream_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Register offsets in 32-bit words from BASE_ADDR.
  localparam logic [2:0] REG_CONST     = 3'd0;
  localparam logic [2:0] REG_NUM       = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_DEPTH     = 3'd4;
  localparam logic [2:0] REG_TRIG_MODE = 3'd5;
  localparam logic [2:0] REG_CHAN      = 3'd6;
  localparam logic [2:0] REG_RAM_DATA  = 3'd7;

  localparam int unsigned NUM_REGS = 8;

  localparam logic [31:0] CONST_VALUE = 32'h5CA7_0001;

  localparam int unsigned CTRL_ARM_BIT   = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  // A single-entry RAM still needs a 1-bit address to keep every port non-empty.
  function automatic int unsigned ram_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_capture_bram.sv
// rtl/stream_capture_bram.sv - simple dual-port RAM, one per capture port
// Purpose: write port fed by the capture path, read port with a single registered
//   output (no extra output register), so rd_data shows mem[rd_addr] one clock later.
// Ports: wr_clk/wr_en/wr_addr/wr_data write side; rd_clk/rd_addr/rd_data read side.
module stream_capture_bram #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge rd_clk) begin
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - arm/trigger capture of parallel sample streams into per-port RAM
// Purpose: records NUM_PORTS x DATA_WIDTH words on valid after an arm and trigger, then
//   exposes them through a 32-bit register bus for readback.
// Ports: clk, reset (async, active-high); data_in/valid sample stream; trig_in external
//   trigger; done_irq completion pulse; bus_addr/bus_wdata/bus_wr/bus_rd/bus_rdata registers.
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int NUM            = 0,
  parameter int BASE_ADDR      = 0,
  parameter int NUM_PORTS      = 1,
  parameter int DATA_WIDTH     = 1,
  parameter int DATA_DEPTH     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic                            valid,
  input  logic                            trig_in,
  output logic                            done_irq,
  input  logic [BUS_ADDR_WIDTH-1:0]       bus_addr,
  input  logic [31:0]                     bus_wdata,
  output logic [31:0]                     bus_rdata,
  input  logic                            bus_wr,
  input  logic                            bus_rd
);

  localparam int RAW = int'(ram_addr_width(DATA_DEPTH));
  localparam int CW  = RAW + 1;
  localparam logic [CW-1:0]             DEPTH_MAX = CW'(DATA_DEPTH);
  localparam logic [RAW-1:0]            PTR_LAST  = RAW'(DATA_DEPTH - 1);
  localparam logic [BUS_ADDR_WIDTH:0]   BASE_EXT  = (BUS_ADDR_WIDTH + 1)'(BASE_ADDR);

  function automatic logic [CW-1:0] clamp_depth(input logic [CW-1:0] d);
    return (d > DEPTH_MAX) ? DEPTH_MAX : d;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   shadow_depth_q, shadow_depth_d;
  logic            trig_mode_q, trig_mode_d;
  logic            shadow_mode_q, shadow_mode_d;
  logic [31:0]     chan_q, chan_d;
  logic [RAW-1:0]  rd_ptr_q, rd_ptr_d;
  logic            irq_q, irq_d;
  logic [31:0]     bus_rdata_q, bus_rdata_d;
  logic            trig_prev_q, trig_prev_d;

  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   port_rd [NUM_PORTS];
  logic [31:0]             ram_word;

  // Extra top bit of the offset is the borrow: set when bus_addr is below the base.
  logic [BUS_ADDR_WIDTH:0] addr_off;
  logic                    addr_hit;
  logic [2:0]              reg_sel;

  assign addr_off = {1'b0, bus_addr} - BASE_EXT;
  assign addr_hit = !addr_off[BUS_ADDR_WIDTH] &&
                    (addr_off[BUS_ADDR_WIDTH-1:0] < BUS_ADDR_WIDTH'(NUM_REGS));
  assign reg_sel  = addr_off[2:0];

  logic wr_hit, rd_hit, cmd_arm, cmd_abort, arm_go, trig_rise, start;
  logic [CW-1:0] count_inc;

  assign wr_hit    = bus_wr && addr_hit;
  assign rd_hit    = bus_rd && addr_hit;
  assign cmd_abort = wr_hit && (reg_sel == REG_CTRL) && bus_wdata[CTRL_ABORT_BIT];
  assign cmd_arm   = wr_hit && (reg_sel == REG_CTRL) && bus_wdata[CTRL_ARM_BIT];
  assign arm_go    = cmd_arm && !cmd_abort;
  assign trig_rise = trig_in && !trig_prev_q;
  assign start     = shadow_mode_q ? trig_rise : valid;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    ram_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (chan_q == 32'(i)) begin
        ram_word = 32'(port_rd[i]);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    count_d        = count_q;
    depth_d        = depth_q;
    shadow_depth_d = shadow_depth_q;
    trig_mode_d    = trig_mode_q;
    shadow_mode_d  = shadow_mode_q;
    chan_d         = chan_q;
    rd_ptr_d       = rd_ptr_q;
    irq_d          = 1'b0;
    bus_rdata_d    = bus_rdata_q;
    trig_prev_d    = trig_in;
    ram_we         = 1'b0;

    if (wr_hit && reg_sel == REG_DEPTH)     depth_d     = bus_wdata[CW-1:0];
    if (wr_hit && reg_sel == REG_TRIG_MODE) trig_mode_d = bus_wdata[0];
    if (wr_hit && reg_sel == REG_CHAN)      chan_d      = bus_wdata;

    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else if (arm_go) begin
      wr_addr_d      = '0;
      count_d        = '0;
      shadow_depth_d = clamp_depth(depth_q);
      shadow_mode_d  = trig_mode_q;
      if (clamp_depth(depth_q) == '0) begin
        state_d = ST_DONE;
        irq_d   = 1'b1;
      end else begin
        state_d = ST_ARMED;
      end
    end else begin
      // The trigger cycle itself captures when valid, so ARMED and CAPTURE share
      // the write path; ARMED just needs the start condition first.
      if ((state_q == ST_CAPTURE || (state_q == ST_ARMED && start)) && valid) begin
        ram_we    = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        count_d   = count_inc;
      end
      if (state_q == ST_ARMED && start) begin
        state_d = ST_CAPTURE;
      end
      if (ram_we && count_inc == shadow_depth_q) begin
        state_d = ST_DONE;
        irq_d   = 1'b1;
      end
    end

    if ((wr_hit && reg_sel == REG_CHAN) || arm_go) begin
      rd_ptr_d = '0;
    end else if (rd_hit && reg_sel == REG_RAM_DATA) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    if (bus_rd) begin
      bus_rdata_d = '0;
      if (addr_hit) begin
        case (reg_sel)
          REG_CONST:     bus_rdata_d = CONST_VALUE;
          REG_NUM:       bus_rdata_d = 32'(NUM);
          REG_STATUS:    bus_rdata_d = {16'(count_q), 14'd0, state_q};
          REG_DEPTH:     bus_rdata_d = 32'(depth_q);
          REG_TRIG_MODE: bus_rdata_d = {31'd0, trig_mode_q};
          REG_CHAN:      bus_rdata_d = chan_q;
          REG_RAM_DATA:  bus_rdata_d = ram_word;
          default:       bus_rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      count_q        <= '0;
      depth_q        <= '0;
      shadow_depth_q <= '0;
      trig_mode_q    <= 1'b0;
      shadow_mode_q  <= 1'b0;
      chan_q         <= '0;
      rd_ptr_q       <= '0;
      irq_q          <= 1'b0;
      bus_rdata_q    <= '0;
      trig_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      count_q        <= count_d;
      depth_q        <= depth_d;
      shadow_depth_q <= shadow_depth_d;
      trig_mode_q    <= trig_mode_d;
      shadow_mode_q  <= shadow_mode_d;
      chan_q         <= chan_d;
      rd_ptr_q       <= rd_ptr_d;
      irq_q          <= irq_d;
      bus_rdata_q    <= bus_rdata_d;
      trig_prev_q    <= trig_prev_d;
    end
  end

  assign done_irq  = irq_q;
  assign bus_rdata = bus_rdata_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    stream_capture_bram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(RAW),
      .DEPTH     (DATA_DEPTH)
    ) u_bram (
      .wr_clk (clk),
      .wr_en  (ram_we),
      .wr_addr(wr_addr_q[RAW-1:0]),
      .wr_data(data_in[DATA_WIDTH*g +: DATA_WIDTH]),
      .rd_clk (clk),
      .rd_addr(rd_ptr_q),
      .rd_data(port_rd[g])
    );
  end

endmodule

// File: tb/tb_stream_capture.sv
// tb/tb_stream_capture.sv - directed self-checking bench for stream_capture
module tb_stream_capture;

  localparam int AW   = 8;
  localparam int BASE = 16;
  localparam logic [AW-1:0] A_CONST  = AW'(BASE + 0);
  localparam logic [AW-1:0] A_NUM    = AW'(BASE + 1);
  localparam logic [AW-1:0] A_CTRL   = AW'(BASE + 2);
  localparam logic [AW-1:0] A_STATUS = AW'(BASE + 3);
  localparam logic [AW-1:0] A_DEPTH  = AW'(BASE + 4);
  localparam logic [AW-1:0] A_TMODE  = AW'(BASE + 5);
  localparam logic [AW-1:0] A_CHAN   = AW'(BASE + 6);
  localparam logic [AW-1:0] A_RAM    = AW'(BASE + 7);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   data_in = '0;
  logic          valid = 1'b0;
  logic          trig_in = 1'b0;
  logic          done_irq;
  logic [AW-1:0] bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_wr = 1'b0;
  logic          bus_rd = 1'b0;

  int checks = 0;
  int errors = 0;

  stream_capture #(
    .BUS_ADDR_WIDTH(AW), .NUM(3), .BASE_ADDR(BASE),
    .NUM_PORTS(2), .DATA_WIDTH(8), .DATA_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .trig_in(trig_in),
    .done_irq(done_irq), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_wr(bus_wr), .bus_rd(bus_rd)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", done_irq); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus_rdata); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", r); end
    bus_read(A_CONST, r);
    checks++; if (r !== 32'h5CA7_0001) begin errors++; $display("FAIL const got %h exp 5ca70001", r); end
    bus_read(A_NUM, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL num got %h exp 3", r); end
    bus_read(AW'(BASE + 8), r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_hi got %h exp 0", r); end
    bus_read(AW'(BASE - 1), r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_lo got %h exp 0", r); end
  endtask

  task automatic test_ramp;
    logic [31:0] r;
    int irq_n = 0;
    bus_write(A_DEPTH, 32'd4);
    bus_read(A_DEPTH, r);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL depth_rb got %h exp 4", r); end
    bus_write(A_TMODE, 32'd0);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_irq) irq_n++;
      valid = 1'b1;
      data_in = {8'(8'h80 + i), 8'(8'h10 + i)};
    end
    @(negedge clk);
    if (done_irq) irq_n++;
    valid = 1'b0;
    @(negedge clk);
    if (done_irq) irq_n++;
    checks++; if (irq_n != 1) begin errors++; $display("FAIL ramp_irq_pulses got %0d exp 1", irq_n); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0004_0003) begin errors++; $display("FAIL ramp_status got %h exp 00040003", r); end
    for (int k = 0; k < 4; k++) begin
      bus_read(A_RAM, r);
      checks++; if (r !== 32'(8'h10 + k)) begin errors++; $display("FAIL ramp_p0_w%0d got %h exp %h", k, r, 32'(8'h10 + k)); end
    end
    bus_write(A_CHAN, 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus_read(A_RAM, r);
      checks++; if (r !== 32'(8'h80 + k)) begin errors++; $display("FAIL ramp_p1_w%0d got %h exp %h", k, r, 32'(8'h80 + k)); end
    end
    bus_write(A_CHAN, 32'd2);
    bus_read(A_RAM, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL chan_oob got %h exp 0", r); end
  endtask

  task automatic test_trigger;
    logic [31:0] r;
    int irq_n = 0;
    int irq_at = -1;
    bus_write(A_DEPTH, 32'd2);
    bus_write(A_TMODE, 32'd1);
    bus_write(A_CTRL, 32'h1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done_irq) begin irq_n++; irq_at = c; end
      valid = 1'b1;
      trig_in = (c >= 10);
      data_in = {8'(c), 8'(8'hA0 + c)};
    end
    @(negedge clk);
    valid = 1'b0; trig_in = 1'b0;
    checks++; if (irq_n != 1 || irq_at != 12) begin errors++; $display("FAIL trig_irq got n=%0d at=%0d exp n=1 at=12", irq_n, irq_at); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0002_0003) begin errors++; $display("FAIL trig_status got %h exp 00020003", r); end
    bus_write(A_CHAN, 32'd0);
    bus_read(A_RAM, r);
    checks++; if (r !== 32'hAA) begin errors++; $display("FAIL trig_w0 got %h exp aa", r); end
    bus_read(A_RAM, r);
    checks++; if (r !== 32'hAB) begin errors++; $display("FAIL trig_w1 got %h exp ab", r); end
  endtask

  task automatic test_valid_gaps;
    logic [31:0] r;
    logic [31:0] exp_w [4];
    int irq_at = -1;
    exp_w[0] = 32'h30; exp_w[1] = 32'h32; exp_w[2] = 32'h34; exp_w[3] = 32'h13;
    bus_write(A_TMODE, 32'd0);
    bus_write(A_DEPTH, 32'd3);
    bus_write(A_CTRL, 32'h1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_irq) irq_at = c;
      valid = (c % 2 == 0);
      data_in = {8'h00, 8'(8'h30 + c)};
    end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (irq_at != 5) begin errors++; $display("FAIL gaps_irq_at got %0d exp 5", irq_at); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0003_0003) begin errors++; $display("FAIL gaps_status got %h exp 00030003", r); end
    bus_write(A_CHAN, 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus_read(A_RAM, r);
      checks++; if (r !== exp_w[k]) begin errors++; $display("FAIL gaps_w%0d got %h exp %h", k, r, exp_w[k]); end
    end
  endtask

  task automatic test_depth_bounds;
    logic [31:0] r;
    int irq_at = -1;
    bus_write(A_DEPTH, 32'd0);
    bus_write(A_CTRL, 32'h1);
    checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL depth0_irq got %0b exp 1", done_irq); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0000_0003) begin errors++; $display("FAIL depth0_status got %h exp 00000003", r); end
    bus_write(A_DEPTH, 32'd13);
    bus_read(A_DEPTH, r);
    checks++; if (r !== 32'd13) begin errors++; $display("FAIL depth13_rb got %h exp d", r); end
    bus_write(A_CTRL, 32'h1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_irq) irq_at = c;
      valid = 1'b1;
      data_in = {8'h00, 8'(8'h40 + c)};
    end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (irq_at != 8) begin errors++; $display("FAIL clamp_irq_at got %0d exp 8", irq_at); end
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0008_0003) begin errors++; $display("FAIL clamp_status got %h exp 00080003", r); end
    bus_write(A_CHAN, 32'd0);
    bus_read(A_RAM, r);
    checks++; if (r !== 32'h40) begin errors++; $display("FAIL clamp_nowrap_w0 got %h exp 40", r); end
  endtask

  task automatic test_abort;
    logic [31:0] r;
    bus_write(A_CTRL, 32'h3);
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0008_0000) begin errors++; $display("FAIL armabort_status got %h exp 00080000", r); end
    bus_write(A_DEPTH, 32'd4);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DEPTH, 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      valid = 1'b1;
      data_in = {8'h00, 8'(8'h60 + c)};
    end
    @(negedge clk);
    valid = 1'b0;
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0002_0002) begin errors++; $display("FAIL shadow_depth_status got %h exp 00020002", r); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0002_0000) begin errors++; $display("FAIL abort_status got %h exp 00020000", r); end
  endtask

  task automatic test_mid_reset_and_readptr;
    logic [31:0] r;
    bus_write(A_DEPTH, 32'd4);
    bus_write(A_TMODE, 32'd1);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TMODE, 32'd0);
    bus_read(A_CONST, r);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid = 1'b1;
      trig_in = (c >= 1);
      data_in = {8'h00, 8'(8'h70 + c)};
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata got %h exp 0", bus_rdata); end
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %0b exp 0", done_irq); end
    @(negedge clk);
    reset = 1'b0; valid = 1'b0; trig_in = 1'b0;
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_status got %h exp 0", r); end
    bus_read(A_DEPTH, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_depth got %h exp 0", r); end
    bus_read(A_TMODE, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_tmode got %h exp 0", r); end
    bus_write(A_DEPTH, 32'd3);
    bus_write(A_CTRL, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid = 1'b1;
      data_in = {8'h00, 8'(8'h50 + c)};
    end
    @(negedge clk);
    valid = 1'b0;
    bus_read(A_RAM, r);
    checks++; if (r !== 32'h50) begin errors++; $display("FAIL rdptr_w0 got %h exp 50", r); end
    bus_read(A_RAM, r);
    checks++; if (r !== 32'h51) begin errors++; $display("FAIL rdptr_w1 got %h exp 51", r); end
    bus_write(A_CHAN, 32'd0);
    bus_read(A_RAM, r);
    checks++; if (r !== 32'h50) begin errors++; $display("FAIL rdptr_chan_clear got %h exp 50", r); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_ramp;
    test_trigger;
    test_valid_gaps;
    test_depth_bounds;
    test_abort;
    test_mid_reset_and_readptr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
